sdram_burst_scheduler: RTL and testbench

- Schedules SDRAM frame-buffer traffic for the video input/output path.
- Arbitrates three burst requesters: one write FIFO (decoded YCbCr from TV decoder) and two read FIFOs (odd field, even field for VGA). Also issues periodic refresh.
- Owns the per-port linear address pointers with base/max wrap.
- Hands one burst command at a time to the SDRAM command engine over a valid/ready + done handshake.

---
 rtl/sdram_burst_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_sdram_burst_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_burst_scheduler.sv
// sdram_burst_scheduler
// Arbitrates SDRAM frame-buffer bursts between one write FIFO (decoded YCbCr), two read FIFOs
// (odd/even field for VGA) and periodic refresh. Owns the per-port linear address pointers with
// base/max wrap, and hands one command at a time to the SDRAM command engine.
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   load_i                      reload all address pointers to their bases
//   wr_level_i                  words held in write FIFO
//   rd1_level_i, rd2_level_i    words held in odd/even-field read FIFOs
//   rd1_en_i, rd2_en_i          read port enables
//   cmd_valid_o / cmd_ready_i   command handshake
//   cmd_type_o                  00 write, 01 read, 10 refresh
//   cmd_port_o                  0 write, 1 rd1, 2 rd2, 3 refresh
//   cmd_addr_o, cmd_len_o       burst start word address and length
//   cmd_done_i                  one-cycle pulse: accepted command completed
//   busy_o                      FSM not idle
//   refresh_overdue_o           sticky: refresh period expired with a refresh still pending
module sdram_burst_scheduler #(
  parameter int unsigned ADDR_W     = 23,
  parameter int unsigned LEN_W      = 9,
  parameter int unsigned BURST_LEN  = 128,
  parameter int unsigned REF_PERIOD = 1562,
  parameter int unsigned WR_BASE    = 0,
  parameter int unsigned WR_MAX     = 324480,
  parameter int unsigned RD1_BASE   = 8320,
  parameter int unsigned RD1_MAX    = 161920,
  parameter int unsigned RD2_BASE   = 170880,
  parameter int unsigned RD2_MAX    = 324480
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic [LEN_W-1:0]  wr_level_i,
  input  logic [LEN_W-1:0]  rd1_level_i,
  input  logic [LEN_W-1:0]  rd2_level_i,
  input  logic              rd1_en_i,
  input  logic              rd2_en_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [1:0]        cmd_type_o,
  output logic [1:0]        cmd_port_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [LEN_W-1:0]  cmd_len_o,
  input  logic              cmd_done_i,
  output logic              busy_o,
  output logic              refresh_overdue_o
);

  localparam int unsigned RefW = $clog2(REF_PERIOD) + 1;
  localparam logic [1:0] PortWr  = 2'd0;
  localparam logic [1:0] PortRd1 = 2'd1;
  localparam logic [1:0] PortRd2 = 2'd2;
  localparam logic [1:0] PortRef = 2'd3;
  localparam logic [1:0] TypeWr  = 2'b00;
  localparam logic [1:0] TypeRd  = 2'b01;
  localparam logic [1:0] TypeRef = 2'b10;

  // One extra bit so pointer + length never overflows silently.
  typedef logic [ADDR_W:0] addr_ext_t;
  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  function automatic addr_ext_t base_of(input logic [1:0] p);
    case (p)
      PortWr:  base_of = addr_ext_t'(WR_BASE);
      PortRd1: base_of = addr_ext_t'(RD1_BASE);
      default: base_of = addr_ext_t'(RD2_BASE);
    endcase
  endfunction

  function automatic addr_ext_t max_of(input logic [1:0] p);
    case (p)
      PortWr:  max_of = addr_ext_t'(WR_MAX);
      PortRd1: max_of = addr_ext_t'(RD1_MAX);
      default: max_of = addr_ext_t'(RD2_MAX);
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        rr_q, rr_d;
  logic [ADDR_W-1:0] ptr_q [3];
  logic [ADDR_W-1:0] ptr_d [3];
  logic [ADDR_W-1:0] ptr_cur [3];
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              overdue_q, overdue_d;
  logic              load_pend_q, load_pend_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_type_q, cmd_type_d;
  logic [1:0]        cmd_port_q, cmd_port_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;

  logic [2:0]        req;
  logic              grant_found;
  logic [1:0]        grant_port;
  logic [1:0]        rr_idx;
  logic [ADDR_W-1:0] grant_addr;
  addr_ext_t         grant_rem;
  logic [LEN_W-1:0]  grant_len;
  addr_ext_t         adv_sum;
  logic [ADDR_W-1:0] adv_ptr;

  assign req[0] = 32'(wr_level_i) >= BURST_LEN;
  assign req[1] = rd1_en_i && (32'(rd1_level_i) < BURST_LEN);
  assign req[2] = rd2_en_i && (32'(rd2_level_i) < BURST_LEN);

  // A load seen in idle takes effect on this edge, so any grant made now starts from the base.
  always_comb begin
    for (int unsigned p = 0; p < 3; p++) begin
      ptr_cur[p] = (state_q == StIdle && load_i) ? ADDR_W'(base_of(2'(p))) : ptr_q[p];
    end
  end

  // Round-robin search starts at the port after the last granted one.
  always_comb begin
    grant_found = 1'b0;
    grant_port  = PortWr;
    rr_idx      = PortWr;
    for (int unsigned k = 1; k <= 3; k++) begin
      rr_idx = 2'((32'(rr_q) + k) % 3);
      if (!grant_found && req[rr_idx]) begin
        grant_found = 1'b1;
        grant_port  = rr_idx;
      end
    end
    unique case (grant_port)
      PortRd1: grant_addr = ptr_cur[1];
      PortRd2: grant_addr = ptr_cur[2];
      default: grant_addr = ptr_cur[0];
    endcase
    grant_rem = max_of(grant_port) - {1'b0, grant_addr};
    grant_len = (grant_rem < addr_ext_t'(BURST_LEN)) ? LEN_W'(grant_rem) : LEN_W'(BURST_LEN);
  end

  // The issued address is the port pointer at grant time, so it seeds the advance.
  always_comb begin
    adv_sum = {1'b0, cmd_addr_q} + addr_ext_t'(cmd_len_q);
    adv_ptr = (adv_sum >= max_of(cmd_port_q)) ? ADDR_W'(base_of(cmd_port_q))
                                              : ADDR_W'(adv_sum);
  end

  always_comb begin
    ref_cnt_d  = ref_cnt_q - 1'b1;
    ref_pend_d = ref_pend_q;
    overdue_d  = overdue_q;
    if (ref_cnt_q == '0) begin
      ref_cnt_d  = RefW'(REF_PERIOD - 1);
      ref_pend_d = 1'b1;
      if (ref_pend_q) overdue_d = 1'b1;
    end else if (state_q == StIssue && cmd_ready_i && cmd_port_q == PortRef) begin
      ref_pend_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    ptr_d       = ptr_q;
    load_pend_d = load_pend_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    cmd_port_d  = cmd_port_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;
    unique case (state_q)
      StIdle: begin
        ptr_d = ptr_cur;
        if (ref_pend_q) begin
          cmd_valid_d = 1'b1;
          cmd_type_d  = TypeRef;
          cmd_port_d  = PortRef;
          cmd_addr_d  = '0;
          cmd_len_d   = '0;
          state_d     = StIssue;
        end else if (grant_found) begin
          cmd_valid_d = 1'b1;
          cmd_type_d  = (grant_port == PortWr) ? TypeWr : TypeRd;
          cmd_port_d  = grant_port;
          cmd_addr_d  = grant_addr;
          cmd_len_d   = grant_len;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (load_i) load_pend_d = 1'b1;
        if (cmd_ready_i) begin
          cmd_valid_d = 1'b0;
          state_d     = StWaitDone;
          if (cmd_port_q != PortRef) rr_d = cmd_port_q;
        end
      end
      StWaitDone: begin
        if (load_i) load_pend_d = 1'b1;
        if (cmd_done_i) begin
          state_d = StIdle;
          if (load_pend_q || load_i) begin
            // Pending reload wins over the completing burst's advance.
            for (int unsigned p = 0; p < 3; p++) ptr_d[p] = ADDR_W'(base_of(2'(p)));
            load_pend_d = 1'b0;
          end else begin
            for (int unsigned p = 0; p < 3; p++) begin
              if (cmd_port_q == 2'(p)) ptr_d[p] = adv_ptr;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      rr_q        <= PortWr;
      for (int unsigned p = 0; p < 3; p++) ptr_q[p] <= ADDR_W'(base_of(2'(p)));
      ref_cnt_q   <= RefW'(REF_PERIOD - 1);
      ref_pend_q  <= 1'b0;
      overdue_q   <= 1'b0;
      load_pend_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_port_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      ptr_q       <= ptr_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      overdue_q   <= overdue_d;
      load_pend_q <= load_pend_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_port_q  <= cmd_port_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  assign cmd_valid_o       = cmd_valid_q;
  assign cmd_type_o        = cmd_type_q;
  assign cmd_port_o        = cmd_port_q;
  assign cmd_addr_o        = cmd_addr_q;
  assign cmd_len_o         = cmd_len_q;
  assign busy_o            = (state_q != StIdle);
  assign refresh_overdue_o = overdue_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Bench for sdram_burst_scheduler: short refresh period and a shortened odd-field region so
// refresh priority, overdue and read wrap are reachable quickly. Expected port commands are
// queued as stimulus is driven and compared as the command engine model accepts them.
module tb_sdram_burst_scheduler;

  localparam int unsigned AddrW     = 23;
  localparam int unsigned LenW      = 9;
  localparam int unsigned RefPeriod = 16;
  localparam int unsigned Rd1Max    = 8320 + 200;

  typedef logic [35:0] cmd_t;

  logic             clk = 1'b0;
  logic             reset, load, rd1_en, rd2_en, cmd_ready, cmd_done;
  logic [LenW-1:0]  wr_level, rd1_level, rd2_level;
  logic             cmd_valid, busy, refresh_overdue;
  logic [1:0]       cmd_type, cmd_port;
  logic [AddrW-1:0] cmd_addr;
  logic [LenW-1:0]  cmd_len;

  int   checks = 0;
  int   errors = 0;
  cmd_t exp_q[$];

  // Refresh bookkeeping model: pend_prev is the pending flag the DUT saw at the last edge.
  int unsigned m_cnt;
  bit          m_pend, m_over, pend_prev;

  always #5 clk = ~clk;

  sdram_burst_scheduler #(
    .REF_PERIOD (RefPeriod),
    .RD1_MAX    (Rd1Max)
  ) u_dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .load_i            (load),
    .wr_level_i        (wr_level),
    .rd1_level_i       (rd1_level),
    .rd2_level_i       (rd2_level),
    .rd1_en_i          (rd1_en),
    .rd2_en_i          (rd2_en),
    .cmd_valid_o       (cmd_valid),
    .cmd_ready_i       (cmd_ready),
    .cmd_type_o        (cmd_type),
    .cmd_port_o        (cmd_port),
    .cmd_addr_o        (cmd_addr),
    .cmd_len_o         (cmd_len),
    .cmd_done_i        (cmd_done),
    .busy_o            (busy),
    .refresh_overdue_o (refresh_overdue)
  );

  always @(posedge clk) begin
    if (reset) begin
      m_cnt     <= RefPeriod - 1;
      m_pend    <= 1'b0;
      m_over    <= 1'b0;
      pend_prev <= 1'b0;
    end else begin
      pend_prev <= m_pend;
      if (m_cnt == 0) begin
        m_cnt  <= RefPeriod - 1;
        m_pend <= 1'b1;
        if (m_pend) m_over <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
        if (cmd_valid && cmd_ready && cmd_port == 2'd3) m_pend <= 1'b0;
      end
    end
  end

  function automatic cmd_t pack(input logic [1:0] t, input logic [1:0] p,
                                input logic [22:0] a, input logic [8:0] l);
    return {t, p, a, l};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0;
    wr_level = '0; rd1_level = '0; rd2_level = '0; cmd_ready = 1'b0; cmd_done = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!cmd_valid && n < 200) begin
      step();
      n++;
    end
    if (!cmd_valid) check("valid_timeout", 64'(cmd_valid), 64'(1));
  endtask

  // Serves commands (refreshes included) until one port burst has completed. The first command
  // seen may be held for 'stall' cycles with stray done pulses; load may pulse during WAIT_DONE.
  task automatic serve_port(input int stall, input bit pulse_load);
    bit   got_port = 1'b0;
    bit   first = 1'b1;
    cmd_t obs;
    int   unstable;
    while (!got_port) begin
      wait_valid();
      if (!cmd_valid) return;
      obs = pack(cmd_type, cmd_port, cmd_addr, cmd_len);
      check("refresh_priority", 64'(cmd_port == 2'd3), 64'(pend_prev));
      check("overdue", 64'(refresh_overdue), 64'(m_over));
      if (cmd_port == 2'd3) begin
        check("refresh_cmd", 64'(obs), 64'(pack(2'b10, 2'd3, 23'd0, 9'd0)));
      end else begin
        got_port = 1'b1;
        if (exp_q.size() == 0) check("cmd_unexpected", 64'(obs), 64'(0));
        else check("cmd", 64'(obs), 64'(exp_q.pop_front()));
      end
      if (first && stall > 0) begin
        unstable = 0;
        for (int i = 0; i < stall; i++) begin
          cmd_done = (i % 2 == 0);
          step();
          if (!cmd_valid || pack(cmd_type, cmd_port, cmd_addr, cmd_len) != obs) unstable++;
        end
        check("hold_stable", 64'(unstable), 64'(0));
        cmd_done = 1'b1;
      end
      first = 1'b0;
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      cmd_done  = 1'b0;
      if (pulse_load && got_port) load = 1'b1;
      step();
      load = 1'b0;
      step();
      step();
      cmd_done = 1'b1;
      step();
      cmd_done = 1'b0;
    end
  endtask

  task automatic expect_port(input logic [1:0] p, input int unsigned a, input int unsigned l);
    exp_q.push_back(pack((p == 2'd0) ? 2'b00 : 2'b01, p, 23'(a), 9'(l)));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0;
    wr_level = '0; rd1_level = '0; rd2_level = '0; cmd_ready = 1'b0; cmd_done = 1'b0;

    // Reset state.
    do_reset();
    check("rst_valid", 64'(cmd_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_overdue", 64'(refresh_overdue), 64'(0));
    check("rst_cmd", 64'(pack(cmd_type, cmd_port, cmd_addr, cmd_len)), 64'(0));
    step();
    check("idle_no_req", 64'(busy), 64'(0));

    // Write-only bursts through the full region and back to 0.
    do_reset();
    wr_level = 9'd128;
    for (int i = 0; i <= 2535; i++) begin
      expect_port(2'd0, (i * 128) % 324480, 128);
      serve_port(0, 1'b0);
    end
    check("wr_queue_drained", 64'(exp_q.size()), 64'(0));

    // Three-way round robin, then load during the rd2 burst at 171008.
    do_reset();
    wr_level = 9'd128;
    expect_port(2'd0, 0, 128);
    serve_port(0, 1'b0);
    rd1_en = 1'b1;
    rd2_en = 1'b1;
    expect_port(2'd1, 8320, 128);   serve_port(0, 1'b0);
    expect_port(2'd2, 170880, 128); serve_port(0, 1'b0);
    expect_port(2'd0, 128, 128);    serve_port(0, 1'b0);
    expect_port(2'd1, 8448, 72);    serve_port(0, 1'b0);
    expect_port(2'd2, 171008, 128); serve_port(0, 1'b1);
    expect_port(2'd0, 0, 128);      serve_port(0, 1'b0);
    expect_port(2'd1, 8320, 128);   serve_port(0, 1'b0);
    expect_port(2'd2, 170880, 128); serve_port(0, 1'b0);
    check("rr_queue_drained", 64'(exp_q.size()), 64'(0));

    // Odd-field wrap with ready stalls; a long stall makes refresh overdue.
    do_reset();
    rd1_en = 1'b1;
    expect_port(2'd1, 8320, 128); serve_port(10, 1'b0);
    expect_port(2'd1, 8448, 72);  serve_port(40, 1'b0);
    check("overdue_set", 64'(refresh_overdue), 64'(1));
    expect_port(2'd1, 8320, 128); serve_port(0, 1'b0);
    expect_port(2'd1, 8448, 72);  serve_port(0, 1'b0);
    check("overdue_sticky", 64'(refresh_overdue), 64'(1));

    // Reset during WAIT_DONE abandons the burst without advancing.
    do_reset();
    wr_level = 9'd128;
    wait_valid();
    check("pre_reset_cmd", 64'(pack(cmd_type, cmd_port, cmd_addr, cmd_len)),
          64'(pack(2'b00, 2'd0, 23'd0, 9'd128)));
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    check("in_wait_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_valid", 64'(cmd_valid), 64'(0));
    check("mid_rst_overdue", 64'(refresh_overdue), 64'(0));
    expect_port(2'd0, 0, 128); serve_port(0, 1'b0);
    rd1_en = 1'b1;
    expect_port(2'd1, 8320, 128); serve_port(0, 1'b0);
    check("final_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
